// File: rtl/event_gate_pkg.sv
// Shared types and default widths for the event gate sequencer.
// The state encodings are exported so the status register map can decode `state`.
package event_gate_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int GATE_W_DEF = 32;
  localparam int HOLD_W_DEF = 16;
  localparam int SEQ_W_DEF  = 16;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_ARMED   = 2'd1;
  localparam logic [1:0] STATE_COUNT   = 2'd2;
  localparam logic [1:0] STATE_HOLDOFF = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = STATE_IDLE,
    ARMED   = STATE_ARMED,
    COUNT   = STATE_COUNT,
    HOLDOFF = STATE_HOLDOFF
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: flags a cycle where d is 1 and its
// previous-cycle copy is 0.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/event_gate_sequencer.sv
// Gated event-counting window sequencer: software/trigger start, optional
// continuous re-arm with hold-off, saturating accumulator and latched result.
module event_gate_sequencer
  import event_gate_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int GATE_W = GATE_W_DEF,
  parameter int HOLD_W = HOLD_W_DEF,
  parameter int SEQ_W  = SEQ_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              trig_en,
  input  logic              exttrig,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              event_pulse,
  output logic              gate,
  output logic              window_start,
  output logic              busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  output logic [SEQ_W-1:0]  result_seq,
  output logic              overflow
);

  state_e            state_q, state_d;
  logic [GATE_W-1:0] gate_timer;
  logic [HOLD_W-1:0] hold_lat, hold_timer;
  logic [CNT_W-1:0]  acc, acc_next;
  logic              start_edge, trig_edge;
  logic              enter_count, finish, clr_ovf, ovf_hit, count_event;

  rise_detect u_start_rd (.clk(clk), .reset(reset), .d(start),   .rise(start_edge));
  rise_detect u_trig_rd  (.clk(clk), .reset(reset), .d(exttrig), .rise(trig_edge));

  assign count_event = (state_q == COUNT) && event_pulse && !stop;
  assign ovf_hit     = count_event && (acc == {CNT_W{1'b1}});
  assign acc_next    = (count_event && !ovf_hit) ? acc + CNT_W'(1) : acc;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    clr_ovf = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start_edge) begin
          clr_ovf = 1'b1;
          state_d = trig_en ? ARMED : COUNT;
        end
        ARMED: if (trig_edge) state_d = COUNT;
        COUNT: if (gate_timer == GATE_W'(1)) begin
          finish = 1'b1;
          if (hold_lat != '0)   state_d = HOLDOFF;
          else if (!continuous) state_d = IDLE;
          else                  state_d = trig_en ? ARMED : COUNT;
        end
        HOLDOFF: if (hold_timer == HOLD_W'(1)) begin
          if (!continuous) state_d = IDLE;
          else             state_d = trig_en ? ARMED : COUNT;
        end
        default: state_d = IDLE;
      endcase
    end
    // Back-to-back windows re-enter COUNT straight from COUNT.
    enter_count = (state_d == COUNT) && ((state_q != COUNT) || finish);
  end

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including the accumulator and timers) has an explicit reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gate_timer   <= '0;
      hold_lat     <= '0;
      hold_timer   <= '0;
      acc          <= '0;
      gate         <= 1'b0;
      window_start <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_seq   <= '0;
      overflow     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate         <= (state_d == COUNT);
      busy         <= (state_d != IDLE);
      window_start <= enter_count;
      result_valid <= finish;

      if (finish) begin
        result     <= acc_next;
        result_seq <= result_seq + SEQ_W'(1);
      end

      if (enter_count) begin
        gate_timer <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        hold_lat   <= holdoff;
        acc        <= '0;
      end else if (stop) begin
        acc <= '0;
      end else if (state_q == COUNT) begin
        gate_timer <= gate_timer - GATE_W'(1);
        acc        <= acc_next;
      end

      if (finish)                  hold_timer <= hold_lat;
      else if (state_q == HOLDOFF) hold_timer <= hold_timer - HOLD_W'(1);

      if (clr_ovf)      overflow <= 1'b0;
      else if (ovf_hit) overflow <= 1'b1;
    end
  end

  assign state = state_q;

endmodule
